cbus_mem_responder: RTL and testbench

- Memory-side end of the CBus protocol: accepts a `cbus_req_t` and drives a `cbus_resp_t`.
- Services single and burst read/write transfers from an internal word-addressed RAM, with programmable access latency.
- Terminates the bus that leaves the arbiter/MMU/cache chain. Used as the simulation memory model and as the on-chip scratch RAM responder.

---
 rtl/cbus_mem_responder_if.sv | 38 +++
 rtl/cbus_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_cbus_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_mem_responder_if.sv
// CBus request/response types and the bus interface connecting an initiator
// to the memory responder. The initiator drives req and the responder drives resp.

package cbus_pkg;

  typedef enum logic {
    BURST_FIXED = 1'b0,
    BURST_INCR  = 1'b1
  } cbus_burst_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    cbus_burst_e burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

interface cbus_mem_responder_if;
  import cbus_pkg::*;

  cbus_req_t  req;
  cbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/cbus_mem_responder.sv
// Memory-side CBus responder: serves single and burst transfers from an
// internal word-addressed RAM after a fixed access latency. Accesses that fall
// outside the mapped window, or transfers abandoned by the initiator, raise a
// sticky oob_err flag.

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cbus_mem_responder_if.slave   bus,
  output logic                  oob_err
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [63:0] WIN_BYTES = 64'(MEM_WORDS) << 3;
  localparam logic [63:0] TOP_ADDR  = BASE_ADDR + WIN_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT,
    DONE
  } state_e;

  state_e      state;
  state_e      next_state;

  logic [63:0] cur_addr;
  logic        is_wr_q;
  logic [3:0]  len_q;
  cbus_burst_e burst_q;
  logic [3:0]  beat;
  logic [3:0]  lat_cnt;

  logic [63:0] mem [MEM_WORDS];

  logic [63:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             last_beat;
  logic             wr_en;

  // The low three address bits select a byte within the word and never
  // affect indexing; the window-relative word index wraps modulo MEM_WORDS.
  assign offset    = cur_addr - BASE_ADDR;
  assign idx       = IDX_W'(offset >> 3);
  assign in_range  = (cur_addr >= BASE_ADDR) && (cur_addr < TOP_ADDR);
  assign last_beat = (beat == len_q);
  assign wr_en     = (state == BEAT) && is_wr_q && bus.req.valid && in_range;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: losing valid in WAIT or BEAT aborts to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req.valid) begin
          next_state = (LATENCY > 0) ? WAIT : BEAT;
        end
      end
      WAIT: begin
        if (!bus.req.valid) begin
          next_state = IDLE;
        end else if (lat_cnt == 4'd1) begin
          next_state = BEAT;
        end
      end
      BEAT: begin
        if (!bus.req.valid) begin
          next_state = IDLE;
        end else if (last_beat) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Response outputs: only BEAT drives the bus; reads are combinational from the RAM.
  always_comb begin
    bus.resp = '0;
    if (state == BEAT) begin
      bus.resp.ready = 1'b1;
      bus.resp.last  = last_beat;
      if (!is_wr_q && in_range) begin
        bus.resp.data = mem[idx];
      end
    end
  end

  // Transfer bookkeeping: request fields are captured once in IDLE, then only
  // the beat counter, latency counter and current address advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr <= '0;
      is_wr_q  <= 1'b0;
      len_q    <= '0;
      burst_q  <= BURST_FIXED;
      beat     <= '0;
      lat_cnt  <= '0;
      oob_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req.valid) begin
            cur_addr <= bus.req.addr;
            is_wr_q  <= bus.req.is_write;
            len_q    <= bus.req.len;
            burst_q  <= bus.req.burst;
            beat     <= '0;
            lat_cnt  <= 4'(LATENCY);
          end
        end
        WAIT: begin
          if (!bus.req.valid) begin
            oob_err <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        BEAT: begin
          if (!bus.req.valid || !in_range) begin
            oob_err <= 1'b1;
          end
          if (bus.req.valid && !last_beat) begin
            beat <= beat + 4'd1;
            if (burst_q == BURST_INCR) begin
              cur_addr <= cur_addr + 64'd8;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM write port: byte-strobed and deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.req.strobe[k]) begin
          mem[idx][8*k +: 8] <= bus.req.data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed testbench for cbus_mem_responder: single/burst reads and writes,
// byte strobes, out-of-range handling, mid-transfer reset and protocol abort.

module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int          LAT   = 2;
  localparam int          WORDS = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic oob_err;
  int   checks   = 0;
  int   failures = 0;

  cbus_mem_responder_if bus_if ();

  cbus_mem_responder #(
    .MEM_WORDS (WORDS),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .oob_err (oob_err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Watchdog so a wedged run still reports and ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [63:0] addr, input logic [3:0] len,
                           input cbus_burst_e burst, input logic [63:0] data,
                           input logic [7:0] strb);
    bus_if.req.valid    = 1'b1;
    bus_if.req.is_write = wr;
    bus_if.req.size     = 3'd3;
    bus_if.req.addr     = addr;
    bus_if.req.len      = len;
    bus_if.req.burst    = burst;
    bus_if.req.data     = data;
    bus_if.req.strobe   = strb;
  endtask

  task automatic end_req();
    bus_if.req = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Single-beat write: accept, LAT wait cycles, one beat, DONE, back to IDLE.
  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb);
    start_req(1'b1, addr, 4'd0, BURST_FIXED, data, strb);
    repeat (LAT + 1) tick();
    tick();
    end_req();
    tick();
  endtask

  // Single-beat read returning what the bus showed during the beat.
  task automatic bus_read(input logic [63:0] addr, output logic [63:0] data,
                          output logic rdy, output logic lst);
    start_req(1'b0, addr, 4'd0, BURST_FIXED, 64'd0, 8'h00);
    repeat (LAT + 1) tick();
    data = bus_if.resp.data;
    rdy  = bus_if.resp.ready;
    lst  = bus_if.resp.last;
    tick();
    end_req();
    tick();
  endtask

  task automatic test_reset();
    bus_if.req = '0;
    #2 reset = 1'b0;
    #10;
    checks++;
    if (bus_if.resp !== '0) begin
      failures++;
      $display("[TB] FAIL reset_resp: got %h expected 0", bus_if.resp);
    end
    checks++;
    if (oob_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_oob: got %b expected 0", oob_err);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (bus_if.resp.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_ready: got %b expected 0", bus_if.resp.ready);
    end
  endtask

  task automatic test_single_read();
    bus_write(BASE, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    start_req(1'b0, BASE, 4'd0, BURST_FIXED, 64'd0, 8'h00);
    tick();
    checks++;
    if (bus_if.resp.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_read_wait_ready: got %b expected 0", bus_if.resp.ready);
    end
    repeat (LAT) tick();
    checks++;
    if (bus_if.resp.ready !== 1'b1 || bus_if.resp.last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_read_handshake: got ready=%b last=%b expected ready=1 last=1",
               bus_if.resp.ready, bus_if.resp.last);
    end
    checks++;
    if (bus_if.resp.data !== 64'hDEAD_BEEF_0123_4567) begin
      failures++;
      $display("[TB] FAIL single_read_data: got %h expected deadbeef01234567", bus_if.resp.data);
    end
    tick();
    checks++;
    if (bus_if.resp !== '0) begin
      failures++;
      $display("[TB] FAIL single_read_done: got %h expected 0", bus_if.resp);
    end
    end_req();
    tick();
    checks++;
    if (oob_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_read_oob: got %b expected 0", oob_err);
    end
  endtask

  task automatic test_strobed_write();
    logic [63:0] rd;
    logic        rdy;
    logic        lst;
    bus_write(BASE + 64'd8, 64'd0, 8'hFF);
    bus_write(BASE + 64'd8, 64'h1122_3344_5566_7788, 8'h0F);
    bus_read(BASE + 64'd8, rd, rdy, lst);
    checks++;
    if (rd !== 64'h0000_0000_5566_7788) begin
      failures++;
      $display("[TB] FAIL strobed_write: got %h expected 0000000055667788", rd);
    end
  endtask

  task automatic test_incr_read_burst();
    for (int i = 0; i < 4; i++) begin
      bus_write(BASE + 64'd16 + 64'(8 * i), 64'(i + 1), 8'hFF);
    end
    start_req(1'b0, BASE + 64'd16, 4'd3, BURST_INCR, 64'd0, 8'h00);
    repeat (LAT + 1) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_if.resp.ready !== 1'b1 || bus_if.resp.data !== 64'(i + 1) ||
          bus_if.resp.last !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL incr_read_beat%0d: got ready=%b last=%b data=%h expected ready=1 last=%b data=%h",
                 i, bus_if.resp.ready, bus_if.resp.last, bus_if.resp.data, (i == 3), 64'(i + 1));
      end
      tick();
    end
    checks++;
    if (bus_if.resp.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL incr_read_done: got ready=%b expected 0", bus_if.resp.ready);
    end
    end_req();
    tick();
  endtask

  task automatic test_fixed_write_burst();
    logic [63:0] rd;
    logic        rdy;
    logic        lst;
    start_req(1'b1, BASE, 4'd2, BURST_FIXED, 64'd5, 8'hFF);
    repeat (LAT + 1) tick();
    tick();
    bus_if.req.data = 64'd6;
    tick();
    bus_if.req.data = 64'd7;
    checks++;
    if (bus_if.resp.last !== 1'b1 || bus_if.resp.data !== 64'd0) begin
      failures++;
      $display("[TB] FAIL fixed_write_last: got last=%b data=%h expected last=1 data=0",
               bus_if.resp.last, bus_if.resp.data);
    end
    tick();
    end_req();
    tick();
    bus_read(BASE, rd, rdy, lst);
    checks++;
    if (rd !== 64'd7) begin
      failures++;
      $display("[TB] FAIL fixed_write_mem0: got %h expected 7", rd);
    end
    bus_read(BASE + 64'd8, rd, rdy, lst);
    checks++;
    if (rd !== 64'h0000_0000_5566_7788) begin
      failures++;
      $display("[TB] FAIL fixed_write_mem1: got %h expected 0000000055667788", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd;
    logic        rdy;
    logic        lst;
    bus_read(BASE - 64'd8, rd, rdy, lst);
    checks++;
    if (rd !== 64'd0 || rdy !== 1'b1 || lst !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oob_read: got data=%h ready=%b last=%b expected data=0 ready=1 last=1",
               rd, rdy, lst);
    end
    checks++;
    if (oob_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oob_read_flag: got %b expected 1", oob_err);
    end
    // A write one word past the top would alias word 0 if it were not dropped.
    bus_write(BASE + 64'(8 * WORDS), 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    bus_read(BASE, rd, rdy, lst);
    checks++;
    if (rd !== 64'd7) begin
      failures++;
      $display("[TB] FAIL oob_write_dropped: got %h expected 7", rd);
    end
    apply_reset();
    bus_write(BASE + 64'(8 * (WORDS - 1)), 64'h0000_0000_0000_ABCD, 8'hFF);
    start_req(1'b0, BASE + 64'(8 * (WORDS - 1)), 4'd1, BURST_INCR, 64'd0, 8'h00);
    repeat (LAT + 1) tick();
    checks++;
    if (bus_if.resp.data !== 64'hABCD || bus_if.resp.last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cross_top_beat0: got data=%h last=%b expected data=abcd last=0",
               bus_if.resp.data, bus_if.resp.last);
    end
    tick();
    checks++;
    if (bus_if.resp.data !== 64'd0 || bus_if.resp.last !== 1'b1 || bus_if.resp.ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cross_top_beat1: got data=%h last=%b ready=%b expected data=0 last=1 ready=1",
               bus_if.resp.data, bus_if.resp.last, bus_if.resp.ready);
    end
    tick();
    end_req();
    tick();
    checks++;
    if (oob_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cross_top_flag: got %b expected 1", oob_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] rd;
    logic        rdy;
    logic        lst;
    apply_reset();
    bus_write(BASE + 64'd80, 64'h55, 8'hFF);
    start_req(1'b1, BASE + 64'd64, 4'd7, BURST_INCR, 64'h100, 8'hFF);
    repeat (LAT + 1) tick();
    tick();
    bus_if.req.data = 64'h101;
    tick();
    bus_if.req.data = 64'h102;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.resp !== '0 || oob_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_burst: got resp=%h oob=%b expected resp=0 oob=0",
               bus_if.resp, oob_err);
    end
    tick();
    end_req();
    reset = 1'b1;
    tick();
    bus_read(BASE + 64'd64, rd, rdy, lst);
    checks++;
    if (rd !== 64'h100) begin
      failures++;
      $display("[TB] FAIL reset_beat0_kept: got %h expected 100", rd);
    end
    bus_read(BASE + 64'd72, rd, rdy, lst);
    checks++;
    if (rd !== 64'h101) begin
      failures++;
      $display("[TB] FAIL reset_beat1_kept: got %h expected 101", rd);
    end
    bus_read(BASE + 64'd80, rd, rdy, lst);
    checks++;
    if (rd !== 64'h55) begin
      failures++;
      $display("[TB] FAIL reset_beat2_unwritten: got %h expected 55", rd);
    end
  endtask

  task automatic test_abort();
    logic [63:0] rd;
    logic        rdy;
    logic        lst;
    start_req(1'b0, BASE, 4'd3, BURST_INCR, 64'd0, 8'h00);
    repeat (LAT + 1) tick();
    tick();
    end_req();
    tick();
    checks++;
    if (oob_err !== 1'b1 || bus_if.resp.ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort: got oob=%b ready=%b expected oob=1 ready=0",
               oob_err, bus_if.resp.ready);
    end
    bus_read(BASE, rd, rdy, lst);
    checks++;
    if (rd !== 64'd7 || rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_recover: got data=%h ready=%b expected data=7 ready=1", rd, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_strobed_write();
    test_incr_read_burst();
    test_fixed_write_burst();
    test_out_of_range();
    test_reset_mid_burst();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
